// File: rtl/mult_pkg.sv
// mult_pkg: shared constants, FSM state type and counter increment for the sequential multiplier
package mult_pkg;
  localparam int MULT_W = 8;
  localparam int CNT_W = 3;
  localparam int MULT_ITERS = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return {c[2] ^ (c[1] & c[0]), c[1] ^ c[0], ~c[0]};
  endfunction
endpackage

// File: rtl/conditional_sum_adder.sv
// conditional_sum_adder: 8-bit combinational conditional-sum adder merging precomputed cin=0/1 blocks
module conditional_sum_adder (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic       cout,
  output logic [7:0] correctSum
);
  logic [7:0] s0, s1, c0, c1, n0, n1, k0, k1;
  logic [2:0] bi, lo, hi;
  always_comb begin
    s0 = x ^ y;
    s1 = ~(x ^ y);
    c0 = x & y;
    c1 = x | y;
    n0 = '0;
    n1 = '0;
    k0 = '0;
    k1 = '0;
    bi = '0;
    lo = '0;
    hi = '0;
    for (int l = 0; l < 3; l++) begin
      n0 = s0;
      n1 = s1;
      k0 = c0;
      k1 = c1;
      for (int i = 0; i < 8; i++) begin
        bi = 3'(i);
        lo = bi & ~(3'd1 << l);
        hi = bi | (3'd1 << l);
        n0[bi] = (bi != lo) ? (c0[lo] ? s1[bi] : s0[bi]) : s0[bi];
        n1[bi] = (bi != lo) ? (c1[lo] ? s1[bi] : s0[bi]) : s1[bi];
        k0[bi] = c0[lo] ? c1[hi] : c0[hi];
        k1[bi] = c1[lo] ? c1[hi] : c0[hi];
      end
      s0 = n0;
      s1 = n1;
      c0 = k0;
      c1 = k1;
    end
    correctSum = cin ? s1 : s0;
    cout = cin ? c1[7] : c0[7];
  end
endmodule

// File: rtl/seq_mult8_csa.sv
// seq_mult8_csa: 8x8 unsigned shift-and-add multiplier iterating once per cycle through conditional_sum_adder
module seq_mult8_csa
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MULT_W-1:0]   a,
  input  logic [MULT_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*MULT_W-1:0] product
);
  state_t state, state_n;
  logic [MULT_W-1:0] mcand, acc_hi, acc_lo, sum;
  logic [CNT_W-1:0] cnt;
  logic cout, last;
  logic [2*MULT_W-1:0] nxt;
  assign last = cnt == CNT_W'(MULT_ITERS - 1);
  assign nxt = {cout, sum, acc_lo[MULT_W-1:1]};
  conditional_sum_adder u_csa (
    .x(acc_hi),
    .y(acc_lo[0] ? mcand : '0),
    .cin(1'b0),
    .cout(cout),
    .correctSum(sum)
  );
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      mcand <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt <= '0;
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= nxt;
      cnt <= cnt_inc(cnt);
      if (last) product <= nxt;
    end
  end
endmodule

// File: tb/tb_seq_mult8_csa.sv
// tb_seq_mult8_csa: scoreboard bench for directed, reset and back-to-back sampled multiplies
module tb_seq_mult8_csa;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic busy, done;
  logic [15:0] product;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  seq_mult8_csa dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .product(product)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input bit hold);
    logic [15:0] prev, e;
    int lat, bcnt;
    bit got;
    prev = product;
    a = ta;
    b = tb_;
    start = 1'b1;
    exp_q.push_back(16'(ta) * 16'(tb_));
    tick();
    lat = 1;
    bcnt = 0;
    got = 1'b0;
    if (hold) begin
      a = 8'hFF;
      b = 8'hFF;
    end else start = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (busy) bcnt++;
      if (lat == 5) chk("prod_hold", product, prev);
      if (done) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    chk("done_seen", got, 1);
    chk("done_lat", lat, 9);
    chk("busy_cyc", bcnt, 9);
    chk("product", product, e);
    tick();
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("prod_keep", product, e);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] cn[6];
    logic [7:0] ba, bb;
    logic [15:0] e;
    int last_done, w;
    bit saw;
    cn = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    rst_n = 1'b1;
    tick();
    run_op(8'h0D, 8'h0B, 1'b0);
    chk("p_0d_0b", product, 16'h008F);
    run_op(8'hFF, 8'hFF, 1'b0);
    chk("p_ff_ff", product, 16'hFE01);
    run_op(8'h00, 8'hFF, 1'b0);
    run_op(8'hA5, 8'h00, 1'b0);
    run_op(8'h12, 8'h34, 1'b1);
    chk("p_hold", product, 16'h03A8);
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    tick();
    chk("rst_wins", busy, 0);
    rst_n = 1'b1;
    start = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      tick();
      saw |= done | busy;
    end
    chk("no_done_after_rst", saw, 0);
    run_op(8'h80, 8'h80, 1'b0);
    chk("p_80_80", product, 16'h4000);
    last_done = 0;
    start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ba = (i < 36) ? cn[i / 6] : 8'($urandom_range(0, 255));
      bb = (i < 36) ? cn[i % 6] : 8'($urandom_range(0, 255));
      a = ba;
      b = bb;
      exp_q.push_back(16'(ba) * 16'(bb));
      w = 0;
      do begin
        tick();
        w++;
      end while (!done && w < 25);
      e = exp_q.pop_front();
      if (!done) begin
        chk("bulk_timeout", 0, 1);
        break;
      end
      chk("bulk_product", product, e);
      if (i > 0) chk("bulk_gap", cyc - last_done, 10);
      last_done = cyc;
    end
    start = 1'b0;
    tick();
    tick();
    chk("final_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
